ysyx_040729_clint_mh: RTL and testbench
=======================================

# ysyx_040729_clint_mh

Multi-hart core-local interruptor, the parametrised successor of the single-hart CLINT. It provides one shared 64-bit `mtime` with a programmable prescaler and a halt input, plus one `mtimecmp` and one `msip` per hart. It sits on the core's MMIO path behind a valid/ready request/response port with one outstanding transaction, and drives per-hart timer and software interrupt lines to the CSR units.

## Interface
- `NUM_HARTS`, 2: number of harts; 1..16.
- `DATA_WIDTH`, 64: bus and timer width; fixed at 64.
- `ADDR_WIDTH`, 16: request address width; the block decodes offset bits `[15:0]`.
- `TICK_COUNT`, 2: `mtime` increments once every `TICK_COUNT+1` enabled cycles; range 0..4095.
- `clock`  in  1  single clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low; deasserted synchronously upstream.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  the block accepts a request this cycle.
- `req_addr`  in  ADDR_WIDTH  byte offset.
- `req_wdata`  in  64  write data, right-aligned (lane 0 = LSB).
- `req_wen`  in  1  1 = write, 0 = read.
- `req_size`  in  3  `[1:0]`: 0 = byte, 1 = half, 2 = word, 3 = dword; `[2]`: 1 = zero-extend the read, 0 = sign-extend.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  64  extended read data; 0 for writes and errors.
- `rsp_err`  out  1  unmapped or misaligned access.
- `time_en`  in  1  0 freezes the prescaler and `mtime` (debug halt).
- `msip`  out  NUM_HARTS  software interrupt per hart.
- `mtip`  out  NUM_HARTS  timer interrupt per hart.

## Operation
- Register map:
  - `msip[h]` at `0x0000+4h`: 32-bit; only bit 0 is stored, upper bits read 0.
  - `mtimecmp[h]` at `0x4000+8h`: 64-bit.
  - `mtime` at `0xBFF8`: 64-bit.
  - Any other offset, including `h >= NUM_HARTS`, is unmapped.
- Alignment: the access must be naturally aligned for `req_size[1:0]`. A dword access to `msip` is misaligned/unmapped. Error accesses are accepted, have no side effects, and respond with `rsp_err=1`.
- Writes are byte-lane merges: only the `1<<size` bytes starting at `addr[2:0]` (`addr[1:0]` for `msip`) are updated, taken from `req_wdata` lane 0 upward. Other bytes are kept.
- Reads: the selected bytes are shifted to the LSB, then zero- or sign-extended to 64 bits according to `req_size[2]`.
- Prescaler: 12-bit counter `pc`. If `time_en` and `pc==TICK_COUNT`: `pc<=0` and `mtime<=mtime+1`. Else if `time_en`: `pc<=pc+1`. Else hold.
- `mtime` wraps from `2^64-1` to 0 with no flag.
- `mtip[h] = (mtime >= mtimecmp[h])`, unsigned compare from registered values, combinational output.
- `msip[h]` = stored bit.
- Simultaneous bus write to `mtime` and a tick: the bus write wins; written bytes take the bus value, unwritten bytes take the incremented value; `pc` still wraps to 0.
- Handshake FSM:
  - IDLE: `req_ready=1`. On `req_valid`, execute the access and move to RESP.
  - RESP: `rsp_valid=1` with `rsp_rdata`/`rsp_err` held stable. `req_ready=rsp_ready`, so a new request can be accepted in the same cycle the response is taken. If `rsp_valid&rsp_ready&req_valid`, stay in RESP with the new response; if `rsp_ready` without a new request, go to IDLE.
- Read data is sampled in the accept cycle. A tick in that same cycle is not visible in the returned value.
- Reset values: `mtime=0`, `pc=0`, every `mtimecmp=0xFFFF_FFFF_FFFF_FFFF` (no spurious interrupt), `msip=0`, FSM=IDLE, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `mtip=0`, `msip` outputs 0. `req_ready=1` once reset is released.
- Reset mid-transaction drops the pending response.

## Timing
- Request accepted at edge N; `rsp_valid=1` after edge N.
- A write is architecturally visible after edge N; `mtip`/`msip` reflect it in cycle N+1.
- Sustained throughput with `rsp_ready=1`: one transaction per cycle.
- First `mtime` increment after reset: edge `TICK_COUNT+1` with `time_en=1`. With `TICK_COUNT=0`, it increments every cycle.

## Structure
- Shared package `ysyx_040729_clint_pkg` holds:
  - offset constants `MSIP_BASE`, `MTIMECMP_BASE`, `MTIME_OFF`;
  - the size encodings;
  - the function that builds the byte-lane write mask from size and offset.
- Sub-module `ysyx_040729_clint_lane_rw`: byte-lane write merge plus read extract/extend for one 64-bit register. Instantiated once for the read path; its mask function is reused by every register.

## Test plan
- Reset, then read `0xBFF8` (dword) with `TICK_COUNT=2` after 9 enabled cycles -> `rdata=3`, `mtip=0`, `msip=0`.
- Write `mtimecmp[1]` dword `=5`, run with `time_en=1` -> `mtip[1]` rises the cycle after `mtime` reaches 5; `mtip[0]` stays 0. Pulse `time_en=0` for 10 cycles -> `mtime` frozen.
- Write byte `0xAB` to `0x4003` over `mtimecmp[0]=0` -> dword read returns `0x00000000AB000000`. Signed byte read of `0x4003` -> `0xFFFFFFFFFFFFFFAB`; zero-extended byte read -> `0xAB`.
- Write `mtime=0xFFFF_FFFF_FFFF_FFFF` -> wraps to 0 on the next tick. A write `mtime=0x10` coinciding with a tick -> reads `0x10`.
- Accesses to `0x0008` with `NUM_HARTS=2`, a dword to `0x0000`, and a half at `0x4001` -> `rsp_err=1`, `rdata=0`, no state change. `msip[1]` write of `0xFFFFFFFF` -> `msip=2'b10`, read returns `1`.
- Back-to-back reads with `rsp_ready` toggling `1,0,1` -> exactly one response per request, data held while stalled, `req_ready` tracks `rsp_ready`. `reset` asserted in RESP -> `rsp_valid=0` asynchronously.

Source files
------------

// File: rtl/ysyx_040729_clint_pkg.sv
// ysyx_040729_clint_pkg: shared offsets, size codes, FSM states and byte-lane helpers
package ysyx_040729_clint_pkg;
  localparam logic [15:0] MSIP_BASE = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_OFF = 16'hBFF8;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic {ST_IDLE, ST_RESP} state_e;
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    base = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
    return base << off;
  endfunction
  function automatic logic [63:0] bit_mask(input logic [7:0] lanes);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{lanes[i]}};
    return m;
  endfunction
  function automatic logic aligned(input logic [1:0] size, input logic [2:0] off);
    return (off & (size == SZ_B ? 3'd0 : size == SZ_H ? 3'd1 : size == SZ_W ? 3'd3 : 3'd7)) == 3'd0;
  endfunction
endpackage

// File: rtl/ysyx_040729_clint_lane_rw.sv
// ysyx_040729_clint_lane_rw: byte-lane write merge and read extract/extend for one 64-bit register
module ysyx_040729_clint_lane_rw import ysyx_040729_clint_pkg::*; (
  input  logic [63:0] old_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  size_i,
  input  logic [2:0]  off_i,
  output logic [63:0] merged_o,
  output logic [63:0] rdata_o
);
  logic [63:0] mask;
  logic [63:0] sh;
  logic sx;
  // write lanes replace the addressed bytes; reads shift the addressed bytes down and extend
  always_comb begin
    mask = bit_mask(lane_mask(size_i[1:0], off_i));
    merged_o = (old_i & ~mask) | ((wdata_i << {off_i, 3'b000}) & mask);
    sh = old_i >> {off_i, 3'b000};
    sx = ~size_i[2];
    rdata_o = size_i[1:0] == SZ_B ? {{56{sx & sh[7]}}, sh[7:0]} :
              size_i[1:0] == SZ_H ? {{48{sx & sh[15]}}, sh[15:0]} :
              size_i[1:0] == SZ_W ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
  end
endmodule

// File: rtl/ysyx_040729_clint_mh.sv
// ysyx_040729_clint_mh: multi-hart CLINT with prescaled mtime, per-hart mtimecmp/msip, valid/ready MMIO port
module ysyx_040729_clint_mh import ysyx_040729_clint_pkg::*; #(
  parameter int NUM_HARTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int TICK_COUNT = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_wen,
  input  logic [2:0]            req_size,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  input  logic                  time_en,
  output logic [NUM_HARTS-1:0]  msip,
  output logic [NUM_HARTS-1:0]  mtip
);
  localparam int HW = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1;
  state_e state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [63:0] mtime_q, mtime_d, mtime_inc, wmask;
  logic [63:0] cmp_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q;
  logic [63:0] rdata_q, rdata_d, sel, merged, extract;
  logic err_q;
  logic [15:0] a;
  logic [2:0] off;
  logic [HW-1:0] hm, hc;
  logic hit_msip, hit_cmp, hit_time, ok, acc, wr, tick;
  assign a = req_addr[15:0];
  // decode the offset into a register, hart index and in-register byte offset
  always_comb begin
    hit_msip = (a - MSIP_BASE) < 16'(4 * NUM_HARTS);
    hit_cmp = (a - MTIMECMP_BASE) < 16'(8 * NUM_HARTS);
    hit_time = a[15:3] == MTIME_OFF[15:3];
    hm = HW'((a - MSIP_BASE) >> 2);
    hc = HW'((a - MTIMECMP_BASE) >> 3);
    off = hit_msip ? {1'b0, a[1:0]} : a[2:0];
    ok = aligned(req_size[1:0], a[2:0]) && ((hit_msip && req_size[1:0] != SZ_D) || hit_cmp || hit_time);
    sel = hit_msip ? 64'(msip_q[hm]) : hit_cmp ? cmp_q[hc] : mtime_q;
  end
  ysyx_040729_clint_lane_rw u_lane (
    .old_i(sel),
    .wdata_i(req_wdata),
    .size_i(req_size),
    .off_i(off),
    .merged_o(merged),
    .rdata_o(extract)
  );
  // handshake: ready in IDLE, in RESP only when the pending response leaves this cycle
  always_comb begin
    req_ready = state_q == ST_IDLE ? 1'b1 : rsp_ready;
    acc = req_valid & req_ready;
    wr = acc & req_wen & ok;
    state_d = acc ? ST_RESP : rsp_ready ? ST_IDLE : state_q;
  end
  // prescaler and mtime; a bus write overrides only its own lanes of the ticked value
  always_comb begin
    tick = time_en && pc_q == 12'(TICK_COUNT);
    pc_d = tick ? 12'd0 : time_en ? pc_q + 12'd1 : pc_q;
    mtime_inc = mtime_q + 64'(tick);
    wmask = bit_mask(lane_mask(req_size[1:0], a[2:0]));
    mtime_d = wr && hit_time ? (mtime_inc & ~wmask) | ((req_wdata << {a[2:0], 3'b000}) & wmask) : mtime_inc;
    rdata_d = ok && !req_wen ? extract : 64'd0;
  end
  // state, timer, per-hart registers and the held response
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q <= '0;
      mtime_q <= '0;
      msip_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) cmp_q[h] <= '1;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      mtime_q <= mtime_d;
      if (acc) begin
        rdata_q <= rdata_d;
        err_q <= !ok;
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && hit_cmp && hc == HW'(h)) cmp_q[h] <= merged;
        if (wr && hit_msip && hm == HW'(h)) msip_q[h] <= merged[0];
      end
    end
  end
  // timer interrupt per hart from registered mtime and mtimecmp
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) mtip[h] = mtime_q >= cmp_q[h];
  end
  assign rsp_valid = state_q == ST_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign msip = msip_q;
endmodule

// File: tb/tb_ysyx_040729_clint_mh.sv
// tb_ysyx_040729_clint_mh: vector table, corner sequences and random traffic against a byte-level model
module tb_ysyx_040729_clint_mh;
  localparam int NH = 2;
  localparam int TC = 2;
  typedef struct {
    bit          wen;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [63:0] rd;
    bit          err;
  } vec_t;
  logic clock = 0, reset = 0, req_valid = 0, req_wen = 0, rsp_ready = 1, time_en = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [15:0] req_addr = 0;
  logic [63:0] req_wdata = 0, rsp_rdata;
  logic [2:0] req_size = 0;
  logic [NH-1:0] msip, mtip;
  int checks = 0, errors = 0;
  longint unsigned m_time, m_next, m_rdata;
  longint unsigned m_cmp [NH];
  int m_pc;
  bit [NH-1:0] m_msip;
  bit m_busy, m_err, last_acc;
  vec_t vt [$];
  logic [15:0] addrs [20] = '{16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0005, 16'h0006, 16'h0007,
                              16'h0008, 16'h4000, 16'h4001, 16'h4004, 16'h4008, 16'h400C, 16'h400F,
                              16'h4010, 16'hBFF8, 16'hBFFC, 16'hBFFF, 16'hBFF0, 16'hC000};

  always #5 clock = ~clock;

  ysyx_040729_clint_mh #(.NUM_HARTS(NH), .DATA_WIDTH(64), .ADDR_WIDTH(16), .TICK_COUNT(TC)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wen(req_wen), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .time_en(time_en), .msip(msip), .mtip(mtip)
  );

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic void mreset();
    m_time = 0; m_pc = 0; m_msip = '0; m_busy = 0; m_rdata = 0; m_err = 0; last_acc = 0;
    for (int h = 0; h < NH; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // register map as byte arrays: locate the register, then read or write whole bytes
  function automatic void macc(bit wen, logic [15:0] a, logic [2:0] sz, logic [63:0] wd);
    int n, off, kind, h;
    longint unsigned v, r, w;
    n = 1 << sz[1:0];
    kind = -1; off = 0; h = 0; v = 0;
    if (a % n == 0) begin
      if (sz[1:0] != 3 && a < 4 * NH) begin kind = 0; h = a / 4; off = a % 4; v = m_msip[h]; end
      else if (a >= 16'h4000 && a < 16'h4000 + 8 * NH) begin kind = 1; h = (a - 16'h4000) / 8; off = a % 8; v = m_cmp[h]; end
      else if (a >= 16'hBFF8 && a <= 16'hBFFF) begin kind = 2; off = a - 16'hBFF8; v = m_time; end
    end
    m_err = kind < 0;
    m_rdata = 0;
    if (kind < 0) return;
    if (!wen) begin
      r = 0;
      for (int i = 0; i < n; i++) r |= ((v >> (8 * (off + i))) & 255) << (8 * i);
      if (!sz[2] && n < 8 && ((r >> (8 * n - 1)) & 1) == 1) r |= ~64'd0 << (8 * n);
      m_rdata = r;
    end else begin
      w = kind == 2 ? m_next : v;
      for (int i = 0; i < n; i++)
        w = (w & ~(64'hFF << (8 * (off + i)))) | (((wd >> (8 * i)) & 255) << (8 * (off + i)));
      if (kind == 0) m_msip[h] = w[0];
      else if (kind == 1) m_cmp[h] = w;
      else m_next = w;
    end
  endfunction

  // one clock: predict the edge from current inputs, then compare every visible output
  task automatic step();
    bit tk;
    logic [NH-1:0] em;
    #1;
    chk("req_ready", req_ready, !m_busy || rsp_ready);
    last_acc = req_valid && (!m_busy || rsp_ready);
    tk = time_en && m_pc == TC;
    m_next = m_time + (tk ? 1 : 0);
    if (time_en) m_pc = tk ? 0 : m_pc + 1;
    if (last_acc) begin
      macc(req_wen, req_addr, req_size, req_wdata);
      m_busy = 1;
    end else if (rsp_ready) m_busy = 0;
    m_time = m_next;
    @(posedge clock); #1;
    chk("rsp_valid", rsp_valid, m_busy);
    if (m_busy) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
    end
    for (int h = 0; h < NH; h++) em[h] = m_time >= m_cmp[h];
    chk("mtip", mtip, em);
    chk("msip", msip, m_msip);
  endtask

  task automatic req(bit wen, logic [15:0] addr, logic [2:0] size, logic [63:0] wd);
    req_valid = 1; req_wen = wen; req_addr = addr; req_size = size; req_wdata = wd;
    step();
    req_valid = 0;
  endtask

  task automatic do_reset();
    reset = 0; req_valid = 0; time_en = 0; rsp_ready = 1;
    @(posedge clock); #1;
    mreset();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mtip", mtip, 0);
    chk("rst_msip", msip, 0);
    chk("rst_req_ready", req_ready, 1);
    reset = 1;
  endtask

  initial begin
    vt.push_back('{1, 16'h4000, 3'd3, 64'h0, 64'h0, 0});
    vt.push_back('{1, 16'h4003, 3'd0, 64'hAB, 64'h0, 0});
    vt.push_back('{0, 16'h4000, 3'd3, 64'h0, 64'h0000_0000_AB00_0000, 0});
    vt.push_back('{0, 16'h4003, 3'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFAB, 0});
    vt.push_back('{0, 16'h4003, 3'd4, 64'h0, 64'hAB, 0});
    vt.push_back('{0, 16'h0008, 3'd2, 64'h0, 64'h0, 1});
    vt.push_back('{0, 16'h0000, 3'd3, 64'h0, 64'h0, 1});
    vt.push_back('{1, 16'h4001, 3'd1, 64'h1234, 64'h0, 1});
    vt.push_back('{0, 16'h4000, 3'd3, 64'h0, 64'h0000_0000_AB00_0000, 0});
    vt.push_back('{1, 16'h0004, 3'd2, 64'hFFFF_FFFF, 64'h0, 0});
    vt.push_back('{0, 16'h0004, 3'd6, 64'h0, 64'h1, 0});
    vt.push_back('{0, 16'h0000, 3'd6, 64'h0, 64'h0, 0});
    vt.push_back('{0, 16'h400E, 3'd1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0});
    vt.push_back('{0, 16'h400E, 3'd5, 64'h0, 64'hFFFF, 0});
    vt.push_back('{1, 16'hBFFC, 3'd2, 64'h8000_0001, 64'h0, 0});
    vt.push_back('{0, 16'hBFF8, 3'd3, 64'h0, 64'h8000_0001_0000_0000, 0});
    vt.push_back('{0, 16'hBFFC, 3'd2, 64'h0, 64'hFFFF_FFFF_8000_0001, 0});
    vt.push_back('{0, 16'hC000, 3'd3, 64'h0, 64'h0, 1});
    vt.push_back('{0, 16'h4010, 3'd3, 64'h0, 64'h0, 1});
    vt.push_back('{1, 16'h0008, 3'd2, 64'h1, 64'h0, 1});
    vt.push_back('{0, 16'h0006, 3'd4, 64'h0, 64'h0, 0});

    do_reset();
    time_en = 1;
    repeat (9) step();
    req(0, 16'hBFF8, 3'd3, 0);
    chk("mtime_after_9", rsp_rdata, 3);
    chk("mtip_after_9", mtip, 0);
    chk("msip_after_9", msip, 0);

    req(1, 16'h4008, 3'd3, 64'd5);
    for (int i = 0; i < 40 && !mtip[1]; i++) step();
    chk("mtip1_rise", mtip, 2'b10);
    time_en = 0;
    req(0, 16'hBFF8, 3'd3, 0);
    chk("mtime_at_rise", rsp_rdata, 5);
    repeat (10) step();
    req(0, 16'hBFF8, 3'd3, 0);
    chk("mtime_frozen", rsp_rdata, 5);

    do_reset();
    foreach (vt[i]) begin
      req(vt[i].wen, vt[i].addr, vt[i].size, vt[i].wdata);
      chk($sformatf("vec%0d_rdata", i), rsp_rdata, vt[i].rd);
      chk($sformatf("vec%0d_err", i), rsp_err, vt[i].err);
    end
    step();
    chk("vec_msip", msip, 2'b10);
    chk("vec_mtip", mtip, 2'b01);

    do_reset();
    req(1, 16'hBFF8, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    time_en = 1;
    repeat (3) step();
    time_en = 0;
    req(0, 16'hBFF8, 3'd3, 0);
    chk("mtime_wrap", rsp_rdata, 0);

    do_reset();
    time_en = 1;
    repeat (2) step();
    req(1, 16'hBFF8, 3'd3, 64'h10);
    time_en = 0;
    req(0, 16'hBFF8, 3'd3, 0);
    chk("write_beats_tick", rsp_rdata, 64'h10);

    do_reset();
    req(1, 16'h4000, 3'd3, 64'h1111);
    req_valid = 1; req_wen = 0; req_addr = 16'h4000; req_size = 3'd3;
    step();
    chk("b2b_first", rsp_rdata, 64'h1111);
    req_addr = 16'h4001; req_size = 3'd4; rsp_ready = 0;
    #1 chk("b2b_stall_ready", req_ready, 0);
    step();
    chk("b2b_held_valid", rsp_valid, 1);
    chk("b2b_held_data", rsp_rdata, 64'h1111);
    rsp_ready = 1;
    #1 chk("b2b_go_ready", req_ready, 1);
    step();
    chk("b2b_second", rsp_rdata, 64'h11);
    req_valid = 0;
    step();
    chk("b2b_idle", rsp_valid, 0);

    req_valid = 1; req_wen = 0; req_addr = 16'hBFF8; req_size = 3'd3;
    step();
    req_valid = 0; rsp_ready = 0;
    step();
    #2 reset = 0;
    #1 chk("async_reset_valid", rsp_valid, 0);
    @(posedge clock); #1;
    mreset();
    reset = 1; rsp_ready = 1;
    step();

    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!req_valid || last_acc) begin
        req_valid = ($urandom % 3) != 0;
        req_wen = $urandom % 2;
        req_addr = ($urandom % 5 == 0) ? 16'($urandom) : addrs[$urandom % 20];
        req_size = 3'($urandom);
        req_wdata = {$urandom, $urandom};
      end
      rsp_ready = ($urandom % 4) != 0;
      time_en = ($urandom % 4) != 0;
      step();
    end
    req_valid = 0; rsp_ready = 1;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
